mole_spawn_ctrl: RTL and testbench

MOLE_SPAWN_CTRL -- requirements
Module: mole_spawn_ctrl

---
 rtl/mole_spawn_ctrl_pkg.sv | 13 +
 rtl/lfsr16.sv | 14 +
 rtl/mole_spawn_ctrl.sv | 87 ++++++++
 tb/tb_mole_spawn_ctrl.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/mole_spawn_ctrl_pkg.sv
// mole_spawn_ctrl_pkg: shared game types, LFSR taps, level codes and spawn position helper
package mole_spawn_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, GAP, SHOW} state_t;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [1:0] LVL_EASY = 2'd0;
  localparam logic [1:0] LVL_MED = 2'd1;
  localparam logic [1:0] LVL_HARD = 2'd2;
  function automatic logic [2:0] next_pos(input logic [2:0] r, input logic [2:0] prev);
    logic [2:0] c;
    c = (r > 3'd4) ? r - 3'd5 : r;
    return (c == prev) ? ((c == 3'd4) ? 3'd0 : c + 3'd1) : c;
  endfunction
endpackage

// File: rtl/lfsr16.sv
// lfsr16: free-running 16-bit Fibonacci LFSR, taps 16,14,13,11
module lfsr16
  import mole_spawn_ctrl_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= SEED;
    else q <= {q[14:0], ^(q & LFSR_TAPS)};
endmodule

// File: rtl/mole_spawn_ctrl.sv
// mole_spawn_ctrl: whack-a-mole spawner with gap, timed show, hit and timeout scoring
module mole_spawn_ctrl
  import mole_spawn_ctrl_pkg::*;
#(
  parameter int unsigned LED_TICKS_EASY = 300_000_000,
  parameter int unsigned LED_TICKS_MED  = 200_000_000,
  parameter int unsigned LED_TICKS_HARD = 100_000_000,
  parameter int unsigned GAP_TICKS      = 50_000_000,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [1:0] level,
  input  logic [4:0] btn_hit_pulse,
  output logic [4:0] mole_led,
  output logic       hit_pulse,
  output logic       timeout_pulse
);
  state_t state, state_n;
  logic [31:0] cnt, cnt_n, limit, limit_n;
  logic [2:0] pos, pos_n;
  logic [4:0] led_n;
  logic hit_n, to_n, hit, last;
  logic [15:0] lfsr;
  logic unused_lfsr;
  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (.clk(clk), .rst_n(rst_n), .q(lfsr));
  assign unused_lfsr = ^lfsr[15:3];
  assign hit = |(btn_hit_pulse & mole_led);
  assign last = cnt == limit - 32'd1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      limit <= '0;
      pos <= '0;
      mole_led <= '0;
      hit_pulse <= 1'b0;
      timeout_pulse <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      limit <= limit_n;
      pos <= pos_n;
      mole_led <= led_n;
      hit_pulse <= hit_n;
      timeout_pulse <= to_n;
    end
  // SHOW spends its first cycle dark lighting the LED; cnt then counts lit cycles
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    limit_n = limit;
    pos_n = pos;
    led_n = mole_led;
    hit_n = 1'b0;
    to_n = 1'b0;
    if (!enable) begin
      state_n = IDLE;
      cnt_n = '0;
      led_n = '0;
    end else
      case (state)
        IDLE: begin
          state_n = GAP;
          cnt_n = '0;
        end
        GAP:
          if (cnt == GAP_TICKS - 32'd1) begin
            state_n = SHOW;
            cnt_n = '0;
            pos_n = next_pos(lfsr[2:0], pos);
            limit_n = (level == LVL_EASY) ? LED_TICKS_EASY : (level == LVL_MED) ? LED_TICKS_MED : LED_TICKS_HARD;
          end else cnt_n = cnt + 32'd1;
        SHOW:
          if (mole_led == '0) led_n = 5'b1 << pos;
          else if (hit || last) begin
            state_n = GAP;
            cnt_n = '0;
            led_n = '0;
            hit_n = hit;
            to_n = !hit;
          end else cnt_n = cnt + 32'd1;
        default: state_n = IDLE;
      endcase
  end
endmodule

// File: tb/tb_mole_spawn_ctrl.sv
// tb_mole_spawn_ctrl: table-driven mole scenarios plus enable-drop and reset corner sequences
module tb_mole_spawn_ctrl;
  logic clk = 0, rst_n = 0, enable = 0;
  logic [1:0] level = 0;
  logic [4:0] btn = 0;
  logic [4:0] mole_led;
  logic hit_pulse, timeout_pulse;
  int tests = 0, fails = 0;
  logic [2:0] prev_pos = 0;
  typedef struct {
    logic [1:0] lvl;
    logic [1:0] lvl2;
    int mode;
    int strike;
    int dark;
    int lit;
    logic hit;
    logic to;
  } vec_t;
  vec_t v[11];
  vec_t r;

  mole_spawn_ctrl #(.LED_TICKS_EASY(30), .LED_TICKS_MED(20), .LED_TICKS_HARD(10), .GAP_TICKS(5), .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .level(level), .btn_hit_pulse(btn),
    .mole_led(mole_led), .hit_pulse(hit_pulse), .timeout_pulse(timeout_pulse));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [2:0] idx(input logic [4:0] l);
    logic [2:0] p = 0;
    for (int i = 0; i < 5; i++) if (l[i]) p = 3'(i);
    return p;
  endfunction

  task automatic note_mole(input string tag);
    check({tag, " onehot"}, 32'($onehot(mole_led)), 1);
    check({tag, " no_repeat"}, 32'(idx(mole_led) != prev_pos), 1);
    prev_pos = idx(mole_led);
  endtask

  task automatic run_mole(input vec_t t, input string tag);
    int dark = 0, lit = 0, bad = 0;
    logic [4:0] led;
    level = t.lvl;
    while (dark < 100) begin
      btn = 5'h1f;
      step();
      if (hit_pulse || timeout_pulse) bad++;
      if (mole_led != 0) break;
      dark++;
    end
    led = mole_led;
    note_mole(tag);
    while (mole_led != 0 && lit < 100) begin
      if (lit == 2) level = t.lvl2;
      btn = (t.mode != 0 && lit == t.strike) ? ((t.mode == 1) ? mole_led : {mole_led[3:0], mole_led[4]}) : 5'h0;
      if (mole_led != led || hit_pulse || timeout_pulse) bad++;
      lit++;
      step();
    end
    btn = 0;
    check({tag, " dark"}, dark, t.dark);
    check({tag, " lit"}, lit, t.lit);
    check({tag, " hit_pulse"}, 32'(hit_pulse), 32'(t.hit));
    check({tag, " timeout_pulse"}, 32'(timeout_pulse), 32'(t.to));
    check({tag, " stray"}, bad, 0);
  endtask

  task automatic wait_lit(input string tag);
    int n = 0;
    while (mole_led == 0 && n < 50) begin
      step();
      n++;
    end
    check({tag, " wait_lit"}, 32'(mole_led != 0), 1);
  endtask

  initial begin
    v[0]  = '{2'd0, 2'd0, 0, -1, 6, 30, 1'b0, 1'b1};
    v[1]  = '{2'd0, 2'd0, 0, -1, 5, 30, 1'b0, 1'b1};
    v[2]  = '{2'd0, 2'd0, 1, 3, 5, 4, 1'b1, 1'b0};
    v[3]  = '{2'd0, 2'd0, 2, 3, 5, 30, 1'b0, 1'b1};
    v[4]  = '{2'd2, 2'd2, 1, 9, 5, 10, 1'b1, 1'b0};
    v[5]  = '{2'd1, 2'd1, 0, -1, 5, 20, 1'b0, 1'b1};
    v[6]  = '{2'd3, 2'd3, 0, -1, 5, 10, 1'b0, 1'b1};
    v[7]  = '{2'd0, 2'd2, 0, -1, 5, 30, 1'b0, 1'b1};
    v[8]  = '{2'd2, 2'd2, 1, 0, 5, 1, 1'b1, 1'b0};
    v[9]  = '{2'd1, 2'd1, 1, 19, 5, 20, 1'b1, 1'b0};
    v[10] = '{2'd1, 2'd1, 2, 19, 5, 20, 1'b0, 1'b1};
    step();
    step();
    check("reset mole_led", 32'(mole_led), 0);
    check("reset hit_pulse", 32'(hit_pulse), 0);
    check("reset timeout_pulse", 32'(timeout_pulse), 0);
    rst_n = 1;
    btn = 5'h1f;
    step();
    step();
    check("idle mole_led", 32'(mole_led), 0);
    check("idle pulses", 32'(hit_pulse | timeout_pulse), 0);
    enable = 1;
    for (int i = 0; i < 11; i++) run_mole(v[i], $sformatf("vec%0d", i));
    r = '{2'd2, 2'd2, 0, -1, 5, 10, 1'b0, 1'b1};
    for (int i = 0; i < 200; i++) run_mole(r, $sformatf("spawn%0d", i));
    wait_lit("drop");
    note_mole("drop");
    for (int i = 0; i < 5; i++) step();
    enable = 0;
    step();
    check("drop mole_led", 32'(mole_led), 0);
    check("drop pulses", 32'(hit_pulse | timeout_pulse), 0);
    btn = 5'h1f;
    for (int i = 0; i < 3; i++) step();
    check("idle hold mole_led", 32'(mole_led), 0);
    check("idle hold pulses", 32'(hit_pulse | timeout_pulse), 0);
    btn = 0;
    enable = 1;
    run_mole(v[0], "reenable");
    wait_lit("rst");
    #2 rst_n = 0;
    #1;
    check("rst mid-show mole_led", 32'(mole_led), 0);
    check("rst mid-show pulses", 32'(hit_pulse | timeout_pulse), 0);
    step();
    check("rst hold pulses", 32'(hit_pulse | timeout_pulse), 0);
    rst_n = 1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
